instruction_fetch: RTL and testbench

Program-counter and fetch unit on the reading side of the 9-bit instruction ROM (8-bit address, combinational read). It drives the ROM address and latches the returned word into a registered instruction output for decode/execute. It applies redirects from execute (relative branch, absolute jump), stall holds, and the HALT encoding. It sequences the core through IDLE, RUN and HALTED.

---
 rtl/isa_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 31 +++
 rtl/instruction_fetch.sv | 104 ++++++++++
 tb/tb_instruction_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-state encoding for the core's front end.
package isa_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 9;

  localparam logic [INSTR_W-1:0] HALT_WORD = 9'b0111_00_010;

  // Opcode field (upper four bits of the instruction word), kept here for the decoder
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_MISC = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: start load, jump, relative branch, increment, else hold.
module pc_next_sel
  import isa_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              start_load,
  input  logic              jump_sel,
  input  logic              branch_sel,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc_next
);

  // Branches are relative to the word in IR, not to the PC that has already moved on
  always_comb begin
    pc_next = pc;
    if (start_load) begin
      pc_next = start_address;
    end else if (jump_sel) begin
      pc_next = jump_target;
    end else if (branch_sel) begin
      pc_next = ADDR_W'(instr_pc + branch_offset);
    end else if (advance) begin
      pc_next = ADDR_W'(pc + ADDR_W'(1));
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Program counter, instruction register and IDLE/RUN/HALTED sequencing for the
// reading side of the instruction ROM.
module instruction_fetch
  import isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_address,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              run_c;
  logic              start_load_c;
  logic              jump_sel_c;
  logic              branch_sel_c;
  logic              halt_sel_c;
  logic              advance_c;

  assign rom_address = pc;

  // Redirects and halt decode only act on a valid IR word and override stall
  assign run_c        = (state == RUN);
  assign start_load_c = start && !run_c;
  assign jump_sel_c   = run_c && instr_valid && jump_en;
  assign branch_sel_c = run_c && instr_valid && branch_taken && !jump_sel_c;
  assign halt_sel_c   = run_c && instr_valid && is_halt(instruction)
                        && !jump_sel_c && !branch_sel_c;
  assign advance_c    = run_c && !jump_sel_c && !branch_sel_c && !halt_sel_c && !stall;

  pc_next_sel u_pc_next_sel (
    .pc            (pc),
    .instr_pc      (instr_pc),
    .start_address (start_address),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .start_load    (start_load_c),
    .jump_sel      (jump_sel_c),
    .branch_sel    (branch_sel_c),
    .advance       (advance_c),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      pc <= pc_next;
      case (state)
        IDLE: begin
          if (start) begin
            instr_valid <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          // A redirect leaves one bubble so the wrong-path word is never presented
          if (jump_sel_c || branch_sel_c) begin
            instr_valid <= 1'b0;
          end else if (halt_sel_c) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= HALTED;
          end else if (!stall) begin
            instruction <= rom_instruction;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            halted      <= 1'b0;
            instr_valid <= 1'b0;
            state       <= RUN;
          end
        end
        default: begin
          instr_valid <= 1'b0;
          halted      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a synthetic ROM.
module tb_instruction_fetch;
  import isa_pkg::*;

  logic               clk;
  logic               reset;
  logic               start;
  logic [ADDR_W-1:0]  start_address;
  logic [ADDR_W-1:0]  rom_address;
  logic [INSTR_W-1:0] rom_instruction;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [ADDR_W-1:0]  instr_pc;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_offset;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_target;
  logic               halted;
  logic               halt_en;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_address   (start_address),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump_en         (jump_en),
    .jump_target     (jump_target),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word = {1, address}; never equals HALT_WORD unless address 19 is armed
  always_comb begin
    rom_instruction = {1'b1, rom_address};
    if (halt_en && rom_address == 8'd19) rom_instruction = HALT_WORD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input int p);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(p);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"}, 32'(instr_pc), 32'(a));
    check({tag, "_ir"}, 32'(instruction), 32'({1'b1, a}));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_rom"}, 32'(rom_address), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_address = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_offset = '0; jump_en = 1'b0; jump_target = '0;
    halt_en = 1'b0;
    #12;
    expect_idle("rst");
    check("rst_ir", 32'(instruction), 32'd0);
    check("rst_ipc", 32'(instr_pc), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    expect_idle("idle_hold");

    // Start at 0, linear fetch
    start = 1'b1; start_address = 8'd0;
    tick();
    start = 1'b0;
    check("start_bubble_valid", 32'(instr_valid), 32'd0);
    check("start_bubble_rom", 32'(rom_address), 32'd0);
    tick();
    expect_fetch("first", 0);
    check("first_rom", 32'(rom_address), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_fetch("lin", k);
      check("lin_rom", 32'(rom_address), 32'(k + 1));
    end

    // Stall three cycles at instr_pc=5
    stall = 1'b1;
    repeat (3) begin
      tick();
      expect_fetch("stall", 5);
      check("stall_rom", 32'(rom_address), 32'd6);
    end
    stall = 1'b0;
    tick(); expect_fetch("unstall6", 6);
    tick(); expect_fetch("unstall7", 7);
    for (int k = 8; k <= 10; k++) begin
      tick(); expect_fetch("to10", k);
    end

    // Backward branch: 10 + 0xFC = 6
    branch_taken = 1'b1; branch_offset = 8'hFC;
    tick();
    branch_taken = 1'b0;
    check("br_bubble_valid", 32'(instr_valid), 32'd0);
    check("br_bubble_rom", 32'(rom_address), 32'd6);
    tick(); expect_fetch("br_target", 6);

    // 6 + 0xFD = 3
    branch_taken = 1'b1; branch_offset = 8'hFD;
    tick();
    branch_taken = 1'b0;
    check("br2_bubble_valid", 32'(instr_valid), 32'd0);
    tick(); expect_fetch("br2_target", 3);

    // Jump beats branch; jump held into the bubble is ignored
    jump_en = 1'b1; jump_target = 8'd16; branch_taken = 1'b1; branch_offset = 8'd2;
    tick();
    branch_taken = 1'b0; jump_target = 8'd40;
    check("jmp_bubble_valid", 32'(instr_valid), 32'd0);
    check("jmp_bubble_rom", 32'(rom_address), 32'd16);
    tick();
    jump_en = 1'b0;
    expect_fetch("jmp_target", 16);
    check("jmp_rom", 32'(rom_address), 32'd17);

    // HALT word at address 19
    halt_en = 1'b1;
    for (int k = 17; k <= 18; k++) begin
      tick(); expect_fetch("to19", k);
    end
    tick();
    check("halt_word_ir", 32'(instruction), 32'(HALT_WORD));
    check("halt_word_pc", 32'(instr_pc), 32'd19);
    check("halt_word_valid", 32'(instr_valid), 32'd1);
    tick();
    check("halted", 32'(halted), 32'd1);
    check("halted_valid", 32'(instr_valid), 32'd0);
    halt_en = 1'b0;
    repeat (20) begin
      tick();
      check("frozen_halted", 32'(halted), 32'd1);
      check("frozen_valid", 32'(instr_valid), 32'd0);
      check("frozen_rom", 32'(rom_address), 32'd20);
      check("frozen_ipc", 32'(instr_pc), 32'd19);
    end

    // Resume from HALTED at 0
    start = 1'b1; start_address = 8'd0;
    tick();
    start = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_valid", 32'(instr_valid), 32'd0);
    check("resume_rom", 32'(rom_address), 32'd0);
    tick(); expect_fetch("resume", 0);

    // Jump to 254, wrap past 255; start in RUN is ignored
    jump_en = 1'b1; jump_target = 8'd254;
    tick();
    jump_en = 1'b0;
    check("j254_bubble_rom", 32'(rom_address), 32'd254);
    tick(); expect_fetch("pc254", 254);
    start = 1'b1; start_address = 8'd100;
    tick();
    start = 1'b0;
    expect_fetch("pc255", 255);
    check("wrap_rom", 32'(rom_address), 32'd0);
    tick(); expect_fetch("wrap0", 0);
    check("wrap_rom1", 32'(rom_address), 32'd1);

    // Asynchronous reset mid-cycle while running
    #3 reset = 1'b1;
    #1 expect_idle("async_rst");
    check("async_rst_ipc", 32'(instr_pc), 32'd0);
    #1 reset = 1'b0;
    repeat (3) begin
      tick(); expect_idle("post_rst_idle");
    end
    start = 1'b1; start_address = 8'd7;
    tick();
    start = 1'b0;
    tick(); expect_fetch("restart", 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
